// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } pipe_state_e;

    // Widest control vector supported; CTRL_NOP is sliced down to the actual width.
    localparam int unsigned CTRL_W_MAX = 64;
    localparam logic [CTRL_W_MAX-1:0] CTRL_NOP = '0;

    localparam int unsigned DATA_W_DEFAULT = 128;
    localparam int unsigned CTRL_W_DEFAULT = 12;

    localparam int unsigned IF_ID_DATA_W  = 64;
    localparam int unsigned IF_ID_CTRL_W  = 4;
    localparam int unsigned ID_EX_DATA_W  = 128;
    localparam int unsigned ID_EX_CTRL_W  = 12;
    localparam int unsigned EX_MEM_DATA_W = 96;
    localparam int unsigned EX_MEM_CTRL_W = 8;
    localparam int unsigned MEM_WB_DATA_W = 64;
    localparam int unsigned MEM_WB_CTRL_W = 4;

endpackage

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush-to-bubble.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned CTRL_W = CTRL_W_DEFAULT
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    localparam logic [CTRL_W-1:0] LP_NOP = CTRL_NOP[CTRL_W-1:0];

    pipe_state_e       r_state;
    pipe_state_e       w_state_next;
    logic [DATA_W-1:0] r_out_data;
    logic [CTRL_W-1:0] r_out_ctrl;
    logic              w_in_xfer;
    logic              w_load_out;
    logic              w_clear_ctrl;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              r_in_ready;
    logic              w_load_skid;
    logic              w_skid_to_out;

    assign in_ready = r_in_ready;
`else
    assign in_ready = out_ready | ~out_valid;
`endif

    assign w_in_xfer = in_valid & in_ready;
    assign out_valid = (r_state != StEmpty);
    assign out_data  = r_out_data;
    assign out_ctrl  = r_out_ctrl;

    always_comb begin
        w_state_next  = r_state;
        w_load_out    = 1'b0;
        w_clear_ctrl  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
`endif
        if (flush) begin
            w_state_next = StEmpty;
            w_clear_ctrl = 1'b1;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_in_xfer) begin
                        w_state_next = StBusy;
                        w_load_out   = 1'b1;
                    end
                end
                StBusy: begin
                    if (w_in_xfer && out_ready) begin
                        w_load_out = 1'b1;
                    end else if (out_ready) begin
                        w_state_next = StEmpty;
                        w_clear_ctrl = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (w_in_xfer) begin
                        w_state_next = StFull;
                        w_load_skid  = 1'b1;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                StFull: begin
                    if (out_ready) begin
                        w_state_next  = StBusy;
                        w_skid_to_out = 1'b1;
                    end
                end
`endif
                default: begin
                    w_state_next = StEmpty;
                    w_clear_ctrl = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= StEmpty;
            r_out_data <= '0;
            r_out_ctrl <= LP_NOP;
        end else begin
            r_state <= w_state_next;
            if (w_load_out) begin
                r_out_data <= in_data;
                r_out_ctrl <= in_ctrl;
`ifdef PIPE_STAGE_SKID_EN
            end else if (w_skid_to_out) begin
                r_out_data <= r_skid_data;
                r_out_ctrl <= r_skid_ctrl;
`endif
            end else if (w_clear_ctrl) begin
                // Bubble: data is kept, only the control vector is squashed.
                r_out_ctrl <= LP_NOP;
            end
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_skid_data <= '0;
            r_skid_ctrl <= LP_NOP;
            r_in_ready  <= 1'b1;
        end else begin
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_ctrl <= in_ctrl;
            end
            r_in_ready <= (w_state_next != StFull);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; a FIFO queue models the words held by the stage.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 12;

    logic          clock = 1'b0;
    logic          resetn = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [DW+CW-1:0] exp_q[$];

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: inputs and outputs are stable at the falling edge; check, then
    // advance the model by what the coming rising edge will transfer.
    always @(negedge clock) begin
        if (!resetn) begin
            exp_q.delete();
            check("reset_out_valid", out_valid, 0);
            check("reset_out_ctrl", out_ctrl, 0);
            check("reset_out_data", out_data, 0);
            check("reset_in_ready", in_ready, 1);
        end else begin
            check("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() == 0) check("bubble_ctrl", out_ctrl, 0);
            else check("head_word", {out_data, out_ctrl}, exp_q[0]);
`ifdef PIPE_STAGE_SKID_EN
            check("in_ready", in_ready, exp_q.size() < 2);
`else
            check("in_ready", in_ready, out_ready || exp_q.size() == 0);
`endif
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                if (in_valid && in_ready) exp_q.push_back({in_data, in_ctrl});
            end
        end
    end

    task automatic xfer(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic fl, input logic ordy, output logic acc);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        flush     = fl;
        out_ready = ordy;
        @(negedge clock);
        acc = iv && in_ready && !fl;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic          acc;
        logic          pend;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        int            sent;
        int            cyc;

        #1 resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            xfer(1'($urandom), $urandom, CW'($urandom), 1'($urandom), 1'($urandom), acc);
        end
        resetn = 1'b1;

        xfer(1'b1, 32'hA5, 12'h001, 1'b0, 1'b1, acc);
        check("first_out_valid", out_valid, 1);
        check("first_out_data", out_data, 32'hA5);

        for (int i = 0; i < 16; i++) begin
            xfer(1'b1, DW'(i), CW'(i + 1), 1'b0, 1'b1, acc);
            check("stream_accept", acc, 1);
            check("stream_in_ready", in_ready, 1);
            check("stream_latency", out_data, DW'(i));
        end
        xfer(1'b0, '0, '0, 1'b0, 1'b1, acc);
        xfer(1'b0, '0, '0, 1'b0, 1'b1, acc);

        // Stall out_ready for 3 cycles while upstream keeps offering words.
        sent = 0;
        cyc  = 0;
        while (sent < 8 && cyc < 50) begin
            xfer(1'b1, DW'(32'h100 + sent), CW'(sent + 3), 1'b0, !(cyc >= 2 && cyc <= 4), acc);
            if (cyc == 2) check("bp_in_ready_low", in_ready, 0);
            if (acc) sent++;
            cyc++;
        end
        check("bp_all_sent", sent, 8);
        for (int i = 0; i < 4; i++) xfer(1'b0, '0, '0, 1'b0, 1'b1, acc);

        xfer(1'b1, 32'hAAA, 12'h0AA, 1'b0, 1'b0, acc);
        xfer(1'b1, 32'hBBB, 12'h0BB, 1'b0, 1'b0, acc);
        xfer(1'b0, '0, '0, 1'b1, 1'b0, acc);
        check("flush_out_valid", out_valid, 0);
        check("flush_out_ctrl", out_ctrl, 0);
        check("flush_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) xfer(1'b0, '0, '0, 1'b0, 1'b1, acc);

        xfer(1'b1, 32'h33, 12'h033, 1'b1, 1'b1, acc);
        check("flush_drop_valid", out_valid, 0);
        xfer(1'b1, 32'h44, 12'h044, 1'b0, 1'b1, acc);
        check("after_flush_valid", out_valid, 1);
        check("after_flush_data", out_data, 32'h44);

`ifndef PIPE_STAGE_SKID_EN
        xfer(1'b1, 32'h55, 12'h055, 1'b0, 1'b0, acc);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1 check("comb_ready_high", in_ready, 1);
        out_ready = 1'b0;
        #1 check("comb_ready_low", in_ready, 0);
`endif
        for (int i = 0; i < 3; i++) xfer(1'b0, '0, '0, 1'b0, 1'b1, acc);

        pend = 1'b0;
        d    = '0;
        c    = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                d    = $urandom;
                c    = CW'($urandom);
                pend = ($urandom_range(0, 9) < 7);
            end
            xfer(pend, d, c, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, acc);
            if (acc) pend = 1'b0;
            if (i == 200) begin
                #2 resetn = 1'b0;
                #1;
                check("async_rst_valid", out_valid, 0);
                check("async_rst_ctrl", out_ctrl, 0);
                check("async_rst_in_ready", in_ready, 1);
                @(posedge clock);
                #1 resetn = 1'b1;
                pend = 1'b0;
            end
        end

        for (int i = 0; i < 4; i++) xfer(1'b0, '0, '0, 1'b0, 1'b1, acc);
        check("drained_out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the general successor to the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) between the datapath stages. It carries one configurable-width data payload plus a control-bit vector, and adds a valid/ready handshake, a 2-entry skid buffer for full throughput with a registered `in_ready`, and a synchronous flush that converts the stage into a bubble. All four inter-stage registers are instantiated from this block with different widths.

## Interface
- `DATA_W`, default 128: payload width (IR, PC, operands, results).
- `CTRL_W`, default 12: control-signal vector width; all-zero encodes a no-op bubble.
- `clock`  in  1: rising-edge clock.
- `resetn`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: upstream stage presents a valid instruction.
- `in_ready`  out  1: stage accepts input this cycle.
- `in_data`  in  DATA_W: payload from upstream.
- `in_ctrl`  in  CTRL_W: control bits from upstream.
- `flush`  in  1: synchronous squash (branch/jump taken).
- `out_valid`  out  1: output holds a valid instruction.
- `out_ready`  in  1: downstream stage consumes output this cycle.
- `out_data`  out  DATA_W: registered payload.
- `out_ctrl`  out  CTRL_W: registered control bits.

## Operation
- Transfer occurs on a rising edge when valid and ready are both high on that side.
- State machine: EMPTY (nothing held), BUSY (output register valid, skid empty), FULL (output and skid both valid).
- EMPTY: `in_valid` -> load output register, go BUSY; else stay.
- BUSY: `in_valid & out_ready` -> reload output, stay BUSY; `in_valid & !out_ready` -> write skid, go FULL; `!in_valid & out_ready` -> go EMPTY; neither -> hold.
- FULL: `out_ready` -> move skid to output, go BUSY; else hold. Input is not accepted in FULL.
- `in_ready` is a register: high exactly when next state is not FULL; it never depends combinationally on `out_ready`.
- `out_valid` is high in BUSY and FULL.
- `out_ctrl` is all-zero whenever `out_valid` is 0 (cleared on entering EMPTY); `out_data` holds its last value.
- `flush` has top priority: next state EMPTY, output and skid invalidated, `out_ctrl` zeroed, any simultaneous input transfer is dropped, `in_ready` 1 next cycle.
- Ordering is strictly FIFO; no data duplication or loss except under flush.

## Timing
- Reset values: state EMPTY, `out_valid` 0, `out_ctrl` 0, `out_data` 0, `in_ready` 1.
- Latency 1 cycle input-to-output when not back-pressured.
- Throughput 1 transfer/cycle sustained with `out_ready` held high.
- Backpressure: `in_ready` falls the cycle after a transfer lands in skid; recovers the cycle after output drains.
- Reset asserted mid-operation clears all state immediately; skid content is discarded.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: behaviour above (3 states, registered `in_ready`).
- Not defined: no skid register; states EMPTY/BUSY only; `in_ready = out_ready | !out_valid` (combinational); flush, bubble and reset rules unchanged; throughput still 1/cycle.

## Structure
- Shared package `pipe_pkg`: state enum (EMPTY, BUSY, FULL), `CTRL_NOP` all-zero constant, default widths per stage.
- No sub-module; the skid register is an inline second bank of the output register.

## Test plan
- Reset: hold `resetn` low with random inputs -> `out_valid` 0, `out_ctrl` 0, `in_ready` 1; release -> first `in_valid` with data 0xA5 appears on `out_data` next cycle.
- Streaming: 16 back-to-back words 0..15, `out_ready` 1 -> outputs 0..15 consecutive cycles, `in_ready` never drops.
- Backpressure: stream, drop `out_ready` for 3 cycles -> exactly one word captured in skid, `in_ready` low after one cycle, no loss/duplication on resume.
- Flush in FULL: fill both entries, pulse `flush` -> next cycle `out_valid` 0, `out_ctrl` 0, `in_ready` 1; neither held word ever emerges.
- Flush with simultaneous `in_valid` (data 0x33) -> 0x33 dropped; next input passes normally.
- Macro off: `out_valid` 1, toggle `out_ready` -> `in_ready` follows it the same cycle; streaming and flush results identical to above.
